// File: rtl/iiitb_vm_pkg.sv
// Shared vending-machine definitions: coin codes carried on the FSM's 2-bit coin bus.
package iiitb_vm_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'b00;
  localparam coin_t COIN_5    = 2'b01;
  localparam coin_t COIN_10   = 2'b10;

endpackage

// File: rtl/iiitb_coin_debounce.sv
// One coin-sensor channel: two-flop synchronizer, debouncer, jam timer and jam flag.
// Emits a one-cycle fall_pulse when a coin has fully passed the sensor.
module iiitb_coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic fall_pulse,
  output logic jammed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_W = $clog2(JAM_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(JAM_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_p2;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == TMR_MAX) ? v : v + 1'b1;
  endfunction

  assign timer_nxt = level_p2 ? sat_inc(timer) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      level_p2   <= 1'b0;
      cnt        <= '0;
      timer      <= '0;
      fall_pulse <= 1'b0;
      jammed     <= 1'b0;
    end else begin
      // p0/p1: metastability guard on the asynchronous sensor
      sync_p0    <= raw;
      sync_p1    <= sync_p0;
      // p2: debounced level; the level flips on the DEBOUNCE_CYCLES-th differing sample
      fall_pulse <= 1'b0;
      if (sync_p1 != level_p2) begin
        if (cnt == CNT_LAST) begin
          level_p2   <= sync_p1;
          cnt        <= '0;
          fall_pulse <= ~sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      timer <= timer_nxt;
      // Jam stays set through the release so the top can still see it with fall_pulse
      if (fall_pulse) begin
        jammed <= 1'b0;
      end else if (timer_nxt == TMR_MAX) begin
        jammed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/iiitb_coin_acceptor.sv
// Coin acceptor front-end: debounces both slot sensors, arbitrates completed passages
// onto the vending FSM coin bus, and reports rejected coins and jammed sensors.
module iiitb_coin_acceptor
  import iiitb_vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       enable,
  output logic [1:0] coin_code,
  output logic       jam,
  output logic       reject
);

  logic fall5, jammed5;
  logic fall10, jammed10;

  iiitb_coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .JAM_CYCLES     (JAM_CYCLES)
  ) u_ch5 (
    .clock     (clock),
    .reset     (reset),
    .raw       (coin5_raw),
    .fall_pulse(fall5),
    .jammed    (jammed5)
  );

  iiitb_coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .JAM_CYCLES     (JAM_CYCLES)
  ) u_ch10 (
    .clock     (clock),
    .reset     (reset),
    .raw       (coin10_raw),
    .fall_pulse(fall10),
    .jammed    (jammed10)
  );

  logic       pend5, pend10;
  logic [1:0] rej_cnt;
  coin_t      code_p3;
  logic       reject_p3;
  logic       jam_p3;

  logic       acc5, acc10, rej5, rej10;
  logic       want5, want10;
  logic       pend5_nxt, pend10_nxt;
  logic [2:0] rej_total;
  logic [1:0] rej_cnt_nxt;
  coin_t      code_nxt;
  logic       reject_nxt;
  logic       jam_nxt;

  always_comb begin
    acc5        = fall5 & enable & ~jammed5;
    acc10       = fall10 & enable & ~jammed10;
    rej5        = fall5 & ~acc5;
    rej10       = fall10 & ~acc10;
    want5       = pend5 | acc5;
    want10      = pend10 | acc10;
    code_nxt    = COIN_NONE;
    // 10 always wins arbitration, so only the 5 flag ever has to wait a cycle
    pend10_nxt  = 1'b0;
    pend5_nxt   = want5 & want10;
    if (want10) begin
      code_nxt = COIN_10;
    end else if (want5) begin
      code_nxt = COIN_5;
    end
    rej_total   = 3'(rej_cnt) + 3'(rej5) + 3'(rej10);
    reject_nxt  = (rej_total != 3'd0);
    rej_cnt_nxt = (rej_total == 3'd0) ? 2'd0 : 2'(rej_total - 3'd1);
    jam_nxt     = (jammed5 & ~fall5) | (jammed10 & ~fall10);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend5     <= 1'b0;
      pend10    <= 1'b0;
      rej_cnt   <= 2'd0;
      code_p3   <= COIN_NONE;
      reject_p3 <= 1'b0;
      jam_p3    <= 1'b0;
    end else begin
      // p3: registered outputs to the vending FSM
      pend5     <= pend5_nxt;
      pend10    <= pend10_nxt;
      rej_cnt   <= rej_cnt_nxt;
      code_p3   <= code_nxt;
      reject_p3 <= reject_nxt;
      jam_p3    <= jam_nxt;
    end
  end

  assign coin_code = code_p3;
  assign reject    = reject_p3;
  assign jam       = jam_p3;

endmodule

// File: doc/iiitb_coin_acceptor.md
# iiitb_coin_acceptor

Front-end for the vending-machine FSM: conditions two raw mechanical coin-sensor lines (5-unit and 10-unit slots) and converts each completed coin passage into a one-cycle coin code on the FSM's 2-bit `in` bus. It also detects jammed sensors and flags rejected coins. It sits directly upstream of the vending FSM, and `coin_code` connects straight to the FSM's coin input.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive identical synchronized samples required to change a debounced level; legal range ≥ 2.
- `JAM_CYCLES`, 1024: debounced-high duration at or above which a channel is declared jammed; must be > `DEBOUNCE_CYCLES`.

Ports:
- `clock` input 1: single clock; all state on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `coin5_raw` input 1: asynchronous 5-unit slot sensor; high while a coin occludes it.
- `coin10_raw` input 1: asynchronous 10-unit slot sensor; high while a coin occludes it.
- `enable` input 1: accept coins when high; when low, completed passages are rejected.
- `coin_code` output 2: 00 none, 01 five, 10 ten; 11 is never driven.
- `jam` output 1: high while either channel is in jam.
- `reject` output 1: one-cycle pulse per discarded coin.

## Operation
- Per channel:
  - two-flop synchronizer;
  - debouncer: a counter increments each cycle the synchronized sample differs from the debounced level and clears when they match; the debounced level flips when the count reaches `DEBOUNCE_CYCLES`;
  - a jam timer counts cycles with debounced high and saturates at `JAM_CYCLES`.
- A coin is credited on the debounced falling edge, meaning the coin has passed the sensor.
- At a falling edge, if `enable` is high and the channel was not jammed, the channel raises its pending flag.
- At a falling edge, if `enable` is low or the channel was jammed, `reject` pulses instead; nothing is credited.
- Jam:
  - a channel becomes jammed when its jam timer reaches `JAM_CYCLES`;
  - the jammed state clears on that channel's debounced falling edge;
  - `jam` is the OR of both channels.
- Output arbitration, evaluated each cycle:
  - if pending10, drive 10 and clear pending10;
  - else if pending5, drive 01 and clear pending5;
  - else drive 00.
- Simultaneous releases on both channels: 10 is driven first, then 01 in the next cycle, with no 00 gap.
- Both channels rejected in the same cycle: `reject` pulses for two consecutive cycles.
- Pending overrun cannot occur, because `DEBOUNCE_CYCLES` ≥ 2 spaces same-channel edges.
- `enable` is sampled at the falling-edge cycle only. Toggling `enable` while a coin is inside the slot has no effect until release.
- Reset mid-operation: synchronizers, counters, debounced levels, pending flags, and jam state all clear. A coin in flight is lost.
  - After reset with raw already high, the channel debounces high normally.
  - The subsequent release is credited only if the jam timer has not expired.

## Timing
- Reset values: `coin_code`=00, `jam`=0, `reject`=0. Debounced levels are 0.
- Latency, for a release that is not arbitrated against the other channel:
  - let edge 0 be the first edge sampling raw low after a stable high;
  - the debounced level falls at edge `DEBOUNCE_CYCLES`+1;
  - `coin_code` is valid in the cycle after edge `DEBOUNCE_CYCLES`+2, i.e. 7 cycles at default.
- Each coin code is asserted for exactly one cycle. `reject` has the same latency as a credited code.
- `jam` asserts in the cycle after the jam timer reaches `JAM_CYCLES`. It deasserts with the same latency as a credited release.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no debounced edge and no output.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `iiitb_vm_pkg`:
  - coin code constants `COIN_NONE`=2'b00, `COIN_5`=2'b01, `COIN_10`=2'b10;
  - these are shared with the vending FSM.
- One sub-module, `iiitb_coin_debounce`, instantiated twice. It contains the synchronizer, debounce counter, jam timer and jam flag, and emits `fall_pulse` and `jammed`.
- The top level holds the pending flags, arbitration, `reject` logic, and output registers.

## Test plan
- 5-slot pulse high for 20 cycles, `enable`=1 -> `coin_code`=01 for one cycle, 7 cycles after release; `reject`=0.
- 10-slot raw toggling every cycle for 3 cycles before a clean 20-cycle high (bounce) -> exactly one 10 code.
- Both slots released on the same edge -> 10 then 01 on consecutive cycles, followed by 00.
- `enable`=0 at release of a 10 coin -> `coin_code` stays 00; `reject` pulses once at the 7-cycle latency.
- 5-slot held high for 1100 cycles -> `jam`=1 at cycle ~1024+5; on release `reject` pulses, no code is emitted, and `jam` drops.
- `reset` asserted mid-debounce of a 10 coin -> all outputs 0 immediately; the coin is not credited.
